ranc_grid_config_loader: RTL and testbench
==========================================

// Module: ranc_grid_config_loader
// PURPOSE
//   Streams configuration words from the SoC bus side into one RANC core's neuron grid.
//   Packs 32-bit beats into PARAM_W-bit neuron parameter entries, then unpacks 2-bit neuron instructions.
//   Drives the grid's param_* and neuron_inst_* write ports, and only writes while the grid is idle.
//   Sits between the LiteX CSR/DMA bridge and the neuron grid; asserts busy so tick generation is held off.
// PARAMETERS
//   DATA_W      32   input beat width
//   PARAM_W     368  neuron parameter entry width
//   NUM_NEURONS 256  parameter entries per load (addresses 0..NUM_NEURONS-1)
//   NUM_AXONS   256  instruction entries per load (addresses 0..NUM_AXONS-1, must be a multiple of 16)
//   Derived: BEATS=ceil(PARAM_W/DATA_W)=12; IPW=DATA_W/2=16 instructions per word.
// PORTS
//   clk                  in   1          core clock, rising edge
//   reset                in   1          async reset, active-high
//   start                in   1          one-cycle pulse that begins a full load
//   in_valid             in   1          input beat valid
//   in_data              in   DATA_W     input beat
//   in_ready             out  1          beat accepted on in_valid & in_ready
//   grid_idle            in   1          high when grid_state is idle (no tick in progress)
//   param_wen            out  1          parameter write strobe
//   param_address        out  8          parameter entry index
//   param_data_in        out  PARAM_W    assembled parameter entry
//   neuron_inst_wen      out  1          instruction write strobe
//   neuron_inst_address  out  8          instruction index
//   neuron_inst_data_in  out  2          instruction value
//   busy                 out  1          high from start acceptance until done
//   done                 out  1          one-cycle pulse after the last instruction write
//   error                out  1          sticky: start received while busy
// BEHAVIOUR
//   Reset: state=IDLE. Every output is 0, including param_data_in, all counters and the assembly register.
//   States: IDLE, LD_PARAM, WR_PARAM, LD_INST, WR_INST, DONE.
//   IDLE: on start, go to LD_PARAM. Clear beat, param_addr, inst_addr and sub; clear error; set busy.
//   LD_PARAM: in_ready=1.
//     - On each handshake, beat k is stored to assembly bits [32k+31:32k] and beat increments.
//     - Beat 11 keeps only in_data[15:0] (bits 367:352); in_data[31:16] is discarded.
//     - The handshake on beat BEATS-1 moves to WR_PARAM.
//   WR_PARAM: in_ready=0.
//     - param_wen = grid_idle, combinational from the registered state.
//     - param_data_in is the assembly register; param_address is param_addr.
//     - When grid_idle, exactly one wen cycle occurs. Then beat=0 and param_addr increments.
//     - Next state is LD_INST if param_addr was NUM_NEURONS-1, else LD_PARAM.
//     - When grid_idle=0, hold state with wen=0 and no limit.
//   Latency: the last beat handshake at edge N gives param_wen high in cycle N+1 if grid_idle.
//   LD_INST: in_ready=1. On handshake, latch the word, set sub=0 and go to WR_INST.
//   WR_INST: in_ready=0.
//     - neuron_inst_wen = grid_idle.
//     - Data is word[2*sub+1:2*sub] (LSB first); address is inst_addr.
//     - On each write, sub and inst_addr increment.
//     - After sub=15: go to DONE if inst_addr was NUM_AXONS-1, else LD_INST.
//     - grid_idle=0 stalls the write without skipping an instruction.
//   DONE: done=1 for one cycle; busy drops in the same cycle. Next state is IDLE.
//   param_wen and neuron_inst_wen are never high together.
//   Address counters wrap naturally at 256 and never exceed their terminal count.
//   start while busy: ignored (the load continues) and error is set; it is cleared only by the next accepted start.
//   start and a beat in the same cycle from IDLE: the beat is not accepted (in_ready=0 in IDLE).
//   in_valid with in_ready=0 is a stall, not an error.
//   in_data must stay stable while in_valid is high.
//   Async reset mid-load: immediate return to IDLE with outputs zeroed.
//     - Any partially assembled entry is lost. Entries already written stay written.
// TESTING
//   1 Params NUM_NEURONS=2, NUM_AXONS=16.
//     - start, 12 beats 0x01..0x0C -> param_wen at addr 0 with data[31:0]=0x01 and [367:352]=0x000C.
//     - Repeat for addr 1, then 1 word -> 16 inst writes.
//     - done pulse, busy falls.
//   2 Inst word 0xE4E4E4E4 -> inst data sequence 0,1,2,3 repeated across addresses 0..15.
//   3 grid_idle=0 for 5 cycles during WR_PARAM -> no wen.
//     - A single wen occurs when idle returns, at the same address; no data loss.
//   4 in_valid toggling (1 of 3 cycles) -> identical written contents to the back-to-back case.
//     - in_ready is low throughout every WR_* state.
//   5 start pulsed mid-load -> error=1 and the load completes normally.
//     - The next start clears error.
//   6 reset asserted at beat 6 of entry 1 -> outputs 0 the same cycle.
//     - A new start reloads from addr 0 correctly.

Source files
------------

// File: rtl/ranc_grid_config_loader.sv
// Streams 32-bit bus beats into a RANC neuron grid: packed parameter
// entries first, then 2-bit neuron instructions, writing only while idle.
module ranc_grid_config_loader #(
  parameter int DATA_W      = 32,
  parameter int PARAM_W     = 368,
  parameter int NUM_NEURONS = 256,
  parameter int NUM_AXONS   = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               grid_idle,
  output logic               param_wen,
  output logic [7:0]         param_address,
  output logic [PARAM_W-1:0] param_data_in,
  output logic               neuron_inst_wen,
  output logic [7:0]         neuron_inst_address,
  output logic [1:0]         neuron_inst_data_in,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int BEATS = (PARAM_W + DATA_W - 1) / DATA_W;
  localparam int IPW   = DATA_W / 2;
  localparam int BW    = $clog2(BEATS);
  localparam int SW    = $clog2(IPW);
  localparam int SHW   = $clog2(PARAM_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_PARAM,
    S_WR_PARAM,
    S_LD_INST,
    S_WR_INST,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [BW-1:0]      r_beat;
  logic [7:0]         r_param_addr;
  logic [7:0]         r_inst_addr;
  logic [SW-1:0]      r_sub;
  logic [PARAM_W-1:0] r_asm;
  logic [DATA_W-1:0]  r_word;
  logic               r_error;

  logic               w_hs;
  logic               w_busy;
  logic [SHW-1:0]     w_sh;
  logic [PARAM_W-1:0] w_ins;
  logic [PARAM_W-1:0] w_msk;

  assign w_hs = in_valid & in_ready;

  // Last beat's surplus bits fall off the top of the entry here.
  assign w_sh  = SHW'(r_beat) * SHW'(DATA_W);
  assign w_ins = PARAM_W'(in_data) << w_sh;
  assign w_msk = PARAM_W'({DATA_W{1'b1}}) << w_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (start) w_next = S_LD_PARAM;
      S_LD_PARAM:
        if (w_hs && r_beat == BW'(BEATS - 1))
          w_next = S_WR_PARAM;
      S_WR_PARAM:
        if (grid_idle)
          w_next = (r_param_addr == 8'(NUM_NEURONS - 1))
                   ? S_LD_INST : S_LD_PARAM;
      S_LD_INST:
        if (w_hs) w_next = S_WR_INST;
      S_WR_INST:
        if (grid_idle && r_sub == SW'(IPW - 1))
          w_next = (r_inst_addr == 8'(NUM_AXONS - 1))
                   ? S_DONE : S_LD_INST;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready        = 1'b0;
    param_wen       = 1'b0;
    neuron_inst_wen = 1'b0;
    done            = 1'b0;
    w_busy          = 1'b0;
    case (r_state)
      S_LD_PARAM: begin
        in_ready = 1'b1;
        w_busy   = 1'b1;
      end
      S_WR_PARAM: begin
        param_wen = grid_idle;
        w_busy    = 1'b1;
      end
      S_LD_INST: begin
        in_ready = 1'b1;
        w_busy   = 1'b1;
      end
      S_WR_INST: begin
        neuron_inst_wen = grid_idle;
        w_busy          = 1'b1;
      end
      S_DONE:
        done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat       <= '0;
      r_param_addr <= '0;
      r_inst_addr  <= '0;
      r_sub        <= '0;
      r_asm        <= '0;
      r_word       <= '0;
      r_error      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_beat       <= '0;
        r_param_addr <= '0;
        r_inst_addr  <= '0;
        r_sub        <= '0;
        r_error      <= 1'b0;
      end else if (start && w_busy) begin
        r_error <= 1'b1;
      end
      if (r_state == S_LD_PARAM && w_hs) begin
        r_asm  <= (r_asm & ~w_msk) | w_ins;
        r_beat <= r_beat + 1'b1;
      end
      if (r_state == S_WR_PARAM && grid_idle) begin
        r_beat       <= '0;
        r_param_addr <= r_param_addr + 8'd1;
      end
      if (r_state == S_LD_INST && w_hs) begin
        r_word <= in_data;
        r_sub  <= '0;
      end
      if (r_state == S_WR_INST && grid_idle) begin
        r_sub       <= r_sub + 1'b1;
        r_inst_addr <= r_inst_addr + 8'd1;
      end
    end
  end

  assign busy                = w_busy;
  assign error               = r_error;
  assign param_address       = r_param_addr;
  assign param_data_in       = r_asm;
  assign neuron_inst_address = r_inst_addr;
  assign neuron_inst_data_in = r_word[{r_sub, 1'b0} +: 2];

endmodule

// File: tb/tb_ranc_grid_config_loader.sv
// Bench for ranc_grid_config_loader: queue model of expected grid writes
// plus directed loads covering stalls, gaps, spurious start and reset.
module tb_ranc_grid_config_loader;

  localparam int NN    = 2;
  localparam int NA    = 16;
  localparam int PW    = 368;
  localparam int BEATS = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          grid_idle;
  logic          param_wen;
  logic [7:0]    param_address;
  logic [PW-1:0] param_data_in;
  logic          neuron_inst_wen;
  logic [7:0]    neuron_inst_address;
  logic [1:0]    neuron_inst_data_in;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  int            pa[$];
  logic [PW-1:0] pd[$];
  int            ia[$];
  logic [1:0]    idv[$];

  logic [PW-1:0] cap_p[NN];
  logic [1:0]    cap_i[NA];
  logic [PW-1:0] sav_p[NN];
  logic [1:0]    sav_i[NA];

  ranc_grid_config_loader #(
    .DATA_W(32), .PARAM_W(PW), .NUM_NEURONS(NN), .NUM_AXONS(NA)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .grid_idle(grid_idle),
    .param_wen(param_wen), .param_address(param_address),
    .param_data_in(param_data_in),
    .neuron_inst_wen(neuron_inst_wen),
    .neuron_inst_address(neuron_inst_address),
    .neuron_inst_data_in(neuron_inst_data_in),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bv(input logic [31:0] seed,
                                     input int e, input int k);
    return seed + 32'(e * 256) + 32'(k + 1);
  endfunction

  // Entry = beats laid end to end, cut to the entry width.
  function automatic logic [PW-1:0] entry(input logic [31:0] seed,
                                          input int e);
    logic [BEATS*32-1:0] f;
    for (int k = 0; k < BEATS; k++) f[k*32 +: 32] = bv(seed, e, k);
    return f[PW-1:0];
  endfunction

  always @(negedge clk) begin : cmp
    int a;
    logic [PW-1:0] d;
    logic [1:0] v;
    if (!reset) begin
      if (param_wen || neuron_inst_wen) begin
        chk("wen_excl", PW'(param_wen & neuron_inst_wen), '0);
        chk("rdy_in_wr", PW'(in_ready), '0);
      end
      if (param_wen) begin
        if (pa.size() == 0) chk("p_unexpected", 1, 0);
        else begin
          a = pa.pop_front();
          d = pd.pop_front();
          chk("p_addr", PW'(param_address), PW'(a));
          chk("p_data", param_data_in, d);
        end
        if (param_address < NN) cap_p[param_address] = param_data_in;
      end
      if (neuron_inst_wen) begin
        if (ia.size() == 0) chk("i_unexpected", 1, 0);
        else begin
          a = ia.pop_front();
          v = idv.pop_front();
          chk("i_addr", PW'(neuron_inst_address), PW'(a));
          chk("i_data", PW'(neuron_inst_data_in), PW'(v));
        end
        if (neuron_inst_address < NA)
          cap_i[neuron_inst_address] = neuron_inst_data_in;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("put_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_entry(input logic [31:0] seed, input int e,
                            input bit gaps, input bit stall,
                            input int mid_k, input int nbeats);
    if (nbeats == BEATS) begin
      pa.push_back(e);
      pd.push_back(entry(seed, e));
    end
    for (int k = 0; k < nbeats; k++) begin
      if (stall && k == BEATS - 1) grid_idle = 1'b0;
      put(bv(seed, e, k));
      if (k == mid_k) begin
        do_start();
        chk("err_set", PW'(error), 1);
        chk("busy_mid", PW'(busy), 1);
      end
      if (gaps && k < BEATS - 1) begin
        tick();
        tick();
      end
    end
    if (nbeats == BEATS) begin
      if (stall) begin
        repeat (5) begin
          chk("stall_wen", PW'(param_wen), 0);
          chk("stall_rdy", PW'(in_ready), 0);
          tick();
        end
        grid_idle = 1'b1;
        #1;
      end
      chk("wen_latency", PW'(param_wen), 1);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int base);
    for (int i = 0; i < 16; i++) begin
      ia.push_back(base + i);
      idv.push_back(2'((w >> (2 * i)) & 32'd3));
    end
    put(w);
    chk("inst_rdy", PW'(in_ready), 0);
    chk("inst_wen", PW'(neuron_inst_wen), 1);
  endtask

  task automatic wait_done;
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", PW'(done), 1);
    chk("busy_at_done", PW'(busy), 0);
    tick();
    chk("done_pulse", PW'(done), 0);
    chk("busy_after", PW'(busy), 0);
    chk("pq_empty", PW'(pa.size()), 0);
    chk("iq_empty", PW'(ia.size()), 0);
  endtask

  task automatic full_load(input logic [31:0] seed, input bit gaps,
                           input bit stall, input int mid_k,
                           input logic [31:0] w);
    do_start();
    chk("busy_start", PW'(busy), 1);
    chk("rdy_start", PW'(in_ready), 1);
    for (int e = 0; e < NN; e++)
      send_entry(seed, e, gaps, stall && e == 0,
                 (e == 0) ? mid_k : -1, BEATS);
    send_word(w, 0);
    wait_done();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, PW'(in_ready), 0);
    chk({nm, "_pwen"}, PW'(param_wen), 0);
    chk({nm, "_paddr"}, PW'(param_address), 0);
    chk({nm, "_pdata"}, param_data_in, '0);
    chk({nm, "_iwen"}, PW'(neuron_inst_wen), 0);
    chk({nm, "_iaddr"}, PW'(neuron_inst_address), 0);
    chk({nm, "_idata"}, PW'(neuron_inst_data_in), 0);
    chk({nm, "_busy"}, PW'(busy), 0);
    chk({nm, "_done"}, PW'(done), 0);
    chk({nm, "_err"}, PW'(error), 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    grid_idle = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    tick();

    // Back-to-back load; instruction pattern 0,1,2,3 repeating.
    full_load(32'h0, 1'b0, 1'b0, -1, 32'hE4E4E4E4);
    chk("t1_p0_lo", PW'(cap_p[0][31:0]), PW'(32'h1));
    chk("t1_p0_hi", PW'(cap_p[0][367:352]), PW'(16'h000C));
    chk("t1_p1_lo", PW'(cap_p[1][31:0]), PW'(32'h101));
    chk("t1_p1_b1", PW'(cap_p[1][63:32]), PW'(32'h102));
    for (int i = 0; i < NA; i++) begin
      chk("t2_inst", PW'(cap_i[i]), PW'(i % 4));
      sav_i[i] = cap_i[i];
    end
    for (int e = 0; e < NN; e++) sav_p[e] = cap_p[e];

    // Grid busy for 5 cycles while an entry waits to be written.
    full_load(32'hDEAD0000, 1'b0, 1'b1, -1, 32'h1B1BC0DE);
    chk("t3_p0_lo", PW'(cap_p[0][31:0]), PW'(32'hDEAD0001));
    chk("t3_p0_hi", PW'(cap_p[0][367:352]), PW'(16'h000C));

    // Sparse valid gives the same contents as back-to-back.
    full_load(32'h0, 1'b1, 1'b0, -1, 32'hE4E4E4E4);
    for (int e = 0; e < NN; e++)
      chk("t4_same_p", cap_p[e], sav_p[e]);
    for (int i = 0; i < NA; i++)
      chk("t4_same_i", PW'(cap_i[i]), PW'(sav_i[i]));

    // Spurious start mid-load sets a sticky error.
    full_load(32'h31000000, 1'b0, 1'b0, 3, 32'h0F0F3355);
    chk("t5_err_sticky", PW'(error), 1);
    do_start();
    chk("t5_err_clr", PW'(error), 0);

    // Reset in the middle of entry 1, then reload from scratch.
    send_entry(32'h77000000, 0, 1'b0, 1'b0, -1, BEATS);
    send_entry(32'h77000000, 1, 1'b0, 1'b0, -1, 6);
    reset = 1'b1;
    #1;
    chk_zero("t6");
    pa.delete();
    pd.delete();
    ia.delete();
    idv.delete();
    @(negedge clk);
    reset = 1'b0;
    tick();
    full_load(32'h5A5A0000, 1'b0, 1'b0, -1, 32'h12345678);
    chk("t6_p0", cap_p[0], entry(32'h5A5A0000, 0));
    chk("t6_p1", cap_p[1], entry(32'h5A5A0000, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
